// File: rtl/uart_rx_fifo_if.sv
// Consumer-side bundle for the UART receive FIFO: head byte handshake, fill level and error pulses.
interface uart_rx_fifo_if #(
    parameter int FifoDepth = 8
);
    localparam int LevelW = $clog2(FifoDepth) + 1;

    logic [7:0]        rx_data_o;
    logic              rx_valid_o;
    logic              rx_ready_i;
    logic [LevelW-1:0] level_o;
    logic              frame_err_o;
    logic              overrun_o;

    modport master (
        output rx_data_o, rx_valid_o, level_o, frame_err_o, overrun_o,
        input  rx_ready_i
    );

    modport slave (
        input  rx_data_o, rx_valid_o, level_o, frame_err_o, overrun_o,
        output rx_ready_i
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with two-flop input synchroniser feeding a first-word-fall-through byte FIFO.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line high, waiting for a start edge
// START     | timing to mid start bit, rejecting glitches
// DATA      | sampling 8 data bits LSB first at bit centres
// STOP      | sampling the stop bit; push byte or flag framing error
// WAIT_IDLE | after a framing error, wait for the line to return high
module uart_rx_fifo #(
    parameter int FPGAClkSpeed = 12000000,
    parameter int BaudRate     = 230400,
    parameter int FifoDepth    = 8
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           uart_rx_i,
    uart_rx_fifo_if.master rx_if
);
    localparam int ClksPerBit = FPGAClkSpeed / BaudRate;
    localparam int CntW       = $clog2(ClksPerBit + 1);
    localparam int AddrW      = $clog2(FifoDepth);

    localparam logic [CntW-1:0] BitTc  = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] HalfTc = CntW'(ClksPerBit / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            sync_q, rxs_q;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic [AddrW:0]  wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]  rd_ptr_q, rd_ptr_d;
    logic [7:0]      mem_q [FifoDepth];

    logic push;
    logic pop;
    logic full;
    logic empty;
    logic wr_en;

    // Bit timing uses a down-counter reloaded per bit; each sample fires on terminal count.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    cnt_d   = HalfTc;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (rxs_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = BitTc;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    cnt_d   = BitTc;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (rxs_q) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            WAIT_IDLE: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign pop   = !empty && rx_if.rx_ready_i;
    assign wr_en = push && (!full || pop);

    always_comb begin
        wr_ptr_d  = wr_ptr_q + (AddrW + 1)'(wr_en);
        rd_ptr_d  = rd_ptr_q + (AddrW + 1)'(pop);
        overrun_d = push && full && !pop;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync_q      <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            sync_q      <= uart_rx_i;
            rxs_q       <= sync_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= shift_d;
        end
    end

    assign rx_if.rx_valid_o  = !empty;
    assign rx_if.rx_data_o   = empty ? 8'h00 : mem_q[rd_ptr_q[AddrW-1:0]];
    assign rx_if.level_o     = wr_ptr_q - rd_ptr_q;
    assign rx_if.frame_err_o = frame_err_q;
    assign rx_if.overrun_o   = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: single bytes, glitch rejection, framing error, overrun, full push+pop, reset.
module tb_uart_rx_fifo;
    localparam int Cpb = 52;

    logic clk;
    logic reset_n;
    logic line;

    int n_chk  = 0;
    int n_pass = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int fe_base;
    int ov_base;
    int lvl_min;

    uart_rx_fifo_if #(.FifoDepth(8)) rx_if ();

    uart_rx_fifo #(
        .FPGAClkSpeed(12000000),
        .BaudRate    (230400),
        .FifoDepth   (8)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset_n),
        .uart_rx_i(line),
        .rx_if    (rx_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each high cycle of a pulse output is counted, so a single-cycle pulse adds exactly one.
    always @(negedge clk) begin
        if (rx_if.frame_err_o) fe_cnt <= fe_cnt + 1;
        if (rx_if.overrun_o)   ov_cnt <= ov_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drives one frame starting at the current negedge; pop_at >= 0 raises ready for that one cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_at, input int ncyc);
        int idx;
        for (int c = 0; c < ncyc; c++) begin
            idx = c / Cpb;
            if (idx == 0)      line = 1'b0;
            else if (idx <= 8) line = b[idx-1];
            else               line = stop;
            if (pop_at >= 0) rx_if.rx_ready_i = (c == pop_at);
            @(negedge clk);
            if (pop_at >= 0 && c >= pop_at - 4 && int'(rx_if.level_o) < lvl_min)
                lvl_min = int'(rx_if.level_o);
        end
        if (stop) line = 1'b1;
    endtask

    task automatic pop_one();
        rx_if.rx_ready_i = 1'b1;
        @(negedge clk);
        rx_if.rx_ready_i = 1'b0;
    endtask

    initial begin
        line             = 1'b1;
        rx_if.rx_ready_i = 1'b0;
        reset_n          = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_level", 32'(rx_if.level_o), 0);
        chk("reset_valid", 32'(rx_if.rx_valid_o), 0);
        chk("reset_data", 32'(rx_if.rx_data_o), 0);
        chk("reset_ferr", 32'(rx_if.frame_err_o), 0);
        chk("reset_ovr", 32'(rx_if.overrun_o), 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(8'hA5, 1'b1, -1, 10 * Cpb);
        repeat (2) @(negedge clk);
        chk("a5_valid", 32'(rx_if.rx_valid_o), 1);
        chk("a5_data", 32'(rx_if.rx_data_o), 32'hA5);
        chk("a5_level", 32'(rx_if.level_o), 1);
        pop_one();
        chk("a5_pop_level", 32'(rx_if.level_o), 0);
        chk("a5_pop_valid", 32'(rx_if.rx_valid_o), 0);
        chk("a5_pop_data", 32'(rx_if.rx_data_o), 0);
        rx_if.rx_ready_i = 1'b1;
        @(negedge clk);
        rx_if.rx_ready_i = 1'b0;
        chk("empty_pop_level", 32'(rx_if.level_o), 0);

        line = 1'b0;
        repeat (10) @(negedge clk);
        line = 1'b1;
        repeat (100) @(negedge clk);
        chk("glitch_level", 32'(rx_if.level_o), 0);
        chk("glitch_valid", 32'(rx_if.rx_valid_o), 0);

        fe_base = fe_cnt;
        send_frame(8'h3C, 1'b0, -1, 10 * Cpb);
        repeat (200) @(negedge clk);
        line = 1'b1;
        repeat (60) @(negedge clk);
        chk("ferr_pulses", 32'(fe_cnt - fe_base), 1);
        chk("ferr_level", 32'(rx_if.level_o), 0);
        send_frame(8'h11, 1'b1, -1, 10 * Cpb);
        repeat (2) @(negedge clk);
        chk("after_ferr_data", 32'(rx_if.rx_data_o), 32'h11);
        chk("after_ferr_level", 32'(rx_if.level_o), 1);
        chk("after_ferr_pulses", 32'(fe_cnt - fe_base), 1);
        pop_one();

        ov_base = ov_cnt;
        for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, -1, 10 * Cpb);
        repeat (2) @(negedge clk);
        chk("ovr_level", 32'(rx_if.level_o), 8);
        chk("ovr_pulses", 32'(ov_cnt - ov_base), 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovr_drain%0d", i), 32'(rx_if.rx_data_o), 32'(i));
            pop_one();
        end
        chk("ovr_drained_valid", 32'(rx_if.rx_valid_o), 0);

        ov_base = ov_cnt;
        for (int i = 0; i < 8; i++) send_frame(8'h20 + 8'(i), 1'b1, -1, 10 * Cpb);
        chk("full_level", 32'(rx_if.level_o), 8);
        lvl_min = 15;
        send_frame(8'h28, 1'b1, 9 * Cpb + Cpb / 2 + 2, 10 * Cpb);
        rx_if.rx_ready_i = 1'b0;
        chk("fullpop_min_level", 32'(lvl_min), 8);
        chk("fullpop_level", 32'(rx_if.level_o), 8);
        chk("fullpop_ovr", 32'(ov_cnt - ov_base), 0);
        for (int i = 1; i < 9; i++) begin
            chk($sformatf("fullpop_drain%0d", i), 32'(rx_if.rx_data_o), 32'h20 + 32'(i));
            pop_one();
        end
        chk("fullpop_empty", 32'(rx_if.rx_valid_o), 0);

        send_frame(8'h30, 1'b1, -1, 10 * Cpb);
        send_frame(8'h31, 1'b1, -1, 10 * Cpb);
        send_frame(8'h32, 1'b1, -1, 10 * Cpb);
        chk("pre_rst_level", 32'(rx_if.level_o), 3);
        send_frame(8'h33, 1'b1, -1, 200);
        reset_n = 1'b0;
        #1;
        chk("midrst_level", 32'(rx_if.level_o), 0);
        chk("midrst_valid", 32'(rx_if.rx_valid_o), 0);
        chk("midrst_data", 32'(rx_if.rx_data_o), 0);
        chk("midrst_ferr", 32'(rx_if.frame_err_o), 0);
        chk("midrst_ovr", 32'(rx_if.overrun_o), 0);
        line = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h5A, 1'b1, -1, 10 * Cpb);
        repeat (2) @(negedge clk);
        chk("post_rst_data", 32'(rx_if.rx_data_o), 32'h5A);
        chk("post_rst_level", 32'(rx_if.level_o), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
